morse_rx: RTL and testbench

Morse receiver and decoder, the receive-side counterpart of the LED Morse transmitter. Samples a push-button key, measures mark and space durations in clock ticks, classifies marks as dit or dah, and decodes each letter to ASCII (A-Z, 0-9). Also detects word gaps and emits a space. Drives the RGB LED (active-low) as a live key echo and status indicator.

---
 rtl/morse_rx.sv | 187 ++++++++++++++++++
 tb/tb_morse_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx.sv
// Morse key receiver: synchronise and debounce the key, time marks and spaces,
// and decode each letter to ASCII. Word gaps produce a space. The RGB LED echoes status.
module morse_rx #(
  parameter logic [23:0] P_UNIT     = 24'h493e00,
  parameter logic [15:0] P_DEBOUNCE = 16'hffff,
  parameter int          P_CNT_W    = 26
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b
);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_WORD} state_t;

  localparam logic [P_CNT_W-1:0] L_DAH     = P_CNT_W'(2 * P_UNIT);
  localparam logic [P_CNT_W-1:0] L_WORD    = P_CNT_W'(5 * P_UNIT);
  localparam logic [15:0]        L_DB_LAST = P_DEBOUNCE - 16'd1;

  state_t               state, state_nxt;
  logic                 sync1, sync2, key_db;
  logic [15:0]          db_cnt;
  logic                 flip, k_rise, k_fall;
  logic [P_CNT_W-1:0]   cnt;
  logic [4:0]           r_sym;
  logic [2:0]           r_len;
  logic                 r_ovf, r_led_b;
  logic                 push, sym_bit, emit_letter, emit_space;
  logic [7:0]           dec_char;
  logic                 dec_err;

  // Edge flags fire in the cycle before key_db changes, so the counter restarts on the same edge.
  assign flip   = (sync2 != key_db) && (db_cnt == L_DB_LAST);
  assign k_rise = flip & sync2;
  assign k_fall = flip & ~sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      key_db <= 1'b0;
      db_cnt <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= i_key;
      sync2 <= sync1;
      if (sync2 == key_db) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt <= '0;
        key_db <= sync2;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
      if (flip)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A threshold hit and a new press in the same cycle both take effect.
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    sym_bit     = 1'b0;
    emit_letter = 1'b0;
    emit_space  = 1'b0;
    case (state)
      S_IDLE:  if (k_rise) state_nxt = S_MARK;
      S_MARK: begin
        if (k_fall) begin
          push      = 1'b1;
          sym_bit   = (cnt >= L_DAH);
          state_nxt = S_SPACE;
        end
      end
      S_SPACE: begin
        if (cnt == L_DAH) begin
          emit_letter = 1'b1;
          state_nxt   = S_WORD;
        end
        if (k_rise) state_nxt = S_MARK;
      end
      S_WORD: begin
        if (cnt == L_WORD) begin
          emit_space = 1'b1;
          state_nxt  = S_IDLE;
        end
        if (k_rise) state_nxt = S_MARK;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dec_char = 8'h3F;
    case ({r_len, r_sym})
      {3'd1, 5'b00000}: dec_char = 8'h45;
      {3'd1, 5'b00001}: dec_char = 8'h54;
      {3'd2, 5'b00000}: dec_char = 8'h49;
      {3'd2, 5'b00001}: dec_char = 8'h41;
      {3'd2, 5'b00010}: dec_char = 8'h4E;
      {3'd2, 5'b00011}: dec_char = 8'h4D;
      {3'd3, 5'b00000}: dec_char = 8'h53;
      {3'd3, 5'b00001}: dec_char = 8'h55;
      {3'd3, 5'b00010}: dec_char = 8'h52;
      {3'd3, 5'b00011}: dec_char = 8'h57;
      {3'd3, 5'b00100}: dec_char = 8'h44;
      {3'd3, 5'b00101}: dec_char = 8'h4B;
      {3'd3, 5'b00110}: dec_char = 8'h47;
      {3'd3, 5'b00111}: dec_char = 8'h4F;
      {3'd4, 5'b00000}: dec_char = 8'h48;
      {3'd4, 5'b00001}: dec_char = 8'h56;
      {3'd4, 5'b00010}: dec_char = 8'h46;
      {3'd4, 5'b00100}: dec_char = 8'h4C;
      {3'd4, 5'b00110}: dec_char = 8'h50;
      {3'd4, 5'b00111}: dec_char = 8'h4A;
      {3'd4, 5'b01000}: dec_char = 8'h42;
      {3'd4, 5'b01001}: dec_char = 8'h58;
      {3'd4, 5'b01010}: dec_char = 8'h43;
      {3'd4, 5'b01011}: dec_char = 8'h59;
      {3'd4, 5'b01100}: dec_char = 8'h5A;
      {3'd4, 5'b01101}: dec_char = 8'h51;
      {3'd5, 5'b01111}: dec_char = 8'h31;
      {3'd5, 5'b00111}: dec_char = 8'h32;
      {3'd5, 5'b00011}: dec_char = 8'h33;
      {3'd5, 5'b00001}: dec_char = 8'h34;
      {3'd5, 5'b00000}: dec_char = 8'h35;
      {3'd5, 5'b10000}: dec_char = 8'h36;
      {3'd5, 5'b11000}: dec_char = 8'h37;
      {3'd5, 5'b11100}: dec_char = 8'h38;
      {3'd5, 5'b11110}: dec_char = 8'h39;
      {3'd5, 5'b11111}: dec_char = 8'h30;
      default:          dec_char = 8'h3F;
    endcase
  end

  assign dec_err = r_ovf | (dec_char == 8'h3F);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sym   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      o_char  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      r_led_b <= 1'b1;
    end else begin
      o_valid <= emit_letter | emit_space;
      o_err   <= emit_letter & dec_err;
      if (emit_letter) begin
        o_char  <= dec_err ? 8'h3F : dec_char;
        r_led_b <= ~dec_err;
        r_sym   <= '0;
        r_len   <= '0;
        r_ovf   <= 1'b0;
      end else if (emit_space) begin
        o_char  <= 8'h20;
        r_led_b <= 1'b1;
      end else if (push) begin
        if (r_len == 3'd5) begin
          r_ovf <= 1'b1;
        end else begin
          r_sym <= {r_sym[3:0], sym_bit};
          r_len <= r_len + 3'd1;
        end
      end
    end
  end

  assign o_led_r = ~key_db;
  assign o_led_g = ~((state == S_MARK) && (cnt >= L_DAH));
  assign o_led_b = r_led_b;

endmodule

// File: tb/tb_morse_rx.sv
// Drives keyed Morse (clean, bouncy and random) into morse_rx and checks every
// decoded character, its timing and the LED status against a table-driven model.
module tb_morse_rx;
  localparam int U  = 10;
  localparam int DB = 2;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic [7:0] o_char;
  logic       o_valid, o_err, o_led_r, o_led_g, o_led_b;

  morse_rx #(.P_UNIT(24'(U)), .P_DEBOUNCE(16'(DB)), .P_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key),
    .o_char(o_char), .o_valid(o_valid), .o_err(o_err),
    .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit lvl; int len; } run_t;
  run_t runs[$];
  int   exp_ch[$], exp_er[$], exp_cy[$];
  int   n_checks = 0, n_fail = 0;

  string tab_code[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic int lookup(input string code);
    for (int i = 0; i < 36; i++)
      if (tab_code[i] == code) return (i < 26) ? (8'h41 + i) : (8'h30 + i - 26);
    return 8'h3F;
  endfunction

  // Every strobe is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err && !o_valid) chk("err_without_valid", int'(o_err), 0);
      if (o_valid) begin
        if (exp_ch.size() == 0) begin
          chk("unexpected_valid", int'(o_valid), 0);
        end else begin
          int ech, eer, ecy;
          ech = exp_ch.pop_front();
          eer = exp_er.pop_front();
          ecy = exp_cy.pop_front();
          chk("char", int'(o_char), ech);
          chk("err", int'(o_err), eer);
          chk("latency_cycle", cyc, ecy);
          chk("led_b", int'(o_led_b), eer ? 0 : 1);
        end
      end
    end
  end

  task automatic add_run(input bit lvl, input int len);
    run_t r;
    r.lvl = lvl;
    r.len = len;
    runs.push_back(r);
  endtask

  task automatic add_code(input string code, input int dit, input int dah,
                          input int intra, input int gap);
    for (int k = 0; k < code.len(); k++) begin
      add_run(1'b1, (code[k] == 8'h2D) ? dah : dit);
      add_run(1'b0, (k == code.len() - 1) ? gap : intra);
    end
  endtask

  // Runs are raw key lengths in cycles; the measured duration is one less, since
  // the counter restarts at 0 on each debounced edge. mode: 0 clean, 1 random glitches, 2 all glitches.
  task automatic play(input int mode, input int tail);
    string code;
    int    f, ch, m;
    code = "";
    if (tail > 0) runs[runs.size() - 1].len += tail;
    foreach (runs[j]) begin
      for (int i = 0; i < runs[j].len; i++) begin
        bit g;
        @(negedge clk);
        if (i == 0) begin
          f = cyc + 1;
          m = runs[j].len - 1;
          if (runs[j].lvl) begin
            if (m >= 2 * U) code = {code, "-"};
            else            code = {code, "."};
          end else if (code.len() > 0 && m >= 2 * U) begin
            ch = lookup(code);
            exp_ch.push_back(ch);
            exp_er.push_back((ch == 8'h3F) ? 1 : 0);
            exp_cy.push_back(f + 2 * U + DB + 2);
            code = "";
            if (m >= 5 * U) begin
              exp_ch.push_back(8'h20);
              exp_er.push_back(0);
              exp_cy.push_back(f + 5 * U + DB + 2);
            end
          end
        end
        if (i == DB + 4 && runs[j].len >= DB + 8)
          chk("led_r", int'(o_led_r), runs[j].lvl ? 0 : 1);
        if (runs[j].lvl && i == runs[j].len - 1) begin
          if (runs[j].len >= 2 * U + DB + 6) chk("led_g_dah", int'(o_led_g), 0);
          else if (runs[j].len <= 2 * U)     chk("led_g_dit", int'(o_led_g), 1);
        end
        g = 1'b0;
        if (mode != 0 && runs[j].len >= 10 && i >= 4 && i <= runs[j].len - 5 && (i % 3) == 1)
          g = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        key = runs[j].lvl ^ g;
      end
    end
    runs.delete();
    @(negedge clk);
    chk("missing_valid", exp_ch.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    key = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_char", int'(o_char), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_led_r", int'(o_led_r), 1);
    chk("rst_led_g", int'(o_led_g), 1);
    chk("rst_led_b", int'(o_led_b), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // SOS at nominal timing
    add_code("...", 11, 31, 11, 31);
    add_code("---", 11, 31, 11, 31);
    add_code("...", 11, 31, 11, 61);
    play(0, 10);

    // One bouncy dit and a bouncy letter gap
    add_code(".", 11, 31, 11, 31);
    add_code(".", 11, 31, 11, 61);
    play(2, 10);

    // Mark of 19 vs 20 ticks, gap of exactly 2U ticks vs 2U-1 ticks before a press
    add_code(".", 20, 21, 11, 41);
    add_code("-", 20, 21, 11, 41);
    add_run(1'b1, 11); add_run(1'b0, 21);
    add_run(1'b1, 11); add_run(1'b0, 20);
    add_run(1'b1, 31); add_run(1'b0, 61);
    play(0, 10);

    // Overflowing six dits, then a clean letter clears the error LED
    add_code("......", 11, 31, 11, 31);
    add_code("-", 11, 31, 11, 61);
    play(0, 10);

    // Undefined .-.-. with the next press landing on the letter-gap cycle
    add_code(".-.-.", 11, 31, 11, 21);
    add_code(".", 11, 31, 11, 61);
    play(0, 10);

    // Reset mid-letter discards the partial letter
    add_code("..", 11, 31, 11, 5);
    play(0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_char", int'(o_char), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_err", int'(o_err), 0);
    chk("midrst_led_r", int'(o_led_r), 1);
    chk("midrst_led_g", int'(o_led_g), 1);
    chk("midrst_led_b", int'(o_led_b), 1);
    rst = 1'b0;
    add_run(1'b0, 80);
    play(0, 0);
    add_code(".-", 11, 31, 11, 61);
    play(0, 10);

    // Random words with jittered timing and occasional glitches
    for (int w = 0; w < 6; w++) begin
      int nch;
      nch = $urandom_range(1, 3);
      for (int c = 0; c < nch; c++) begin
        int idx, gap;
        idx = $urandom_range(0, 35);
        gap = (c == nch - 1) ? $urandom_range(51, 70) : $urandom_range(21, 50);
        add_code(tab_code[idx], $urandom_range(4, 20), $urandom_range(21, 40),
                 $urandom_range(4, 20), gap);
      end
      play(1, 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
